// File: rtl/bus_controller_pkg.sv
// Shared snoop-bus types: CPU count, bus command and controller state encodings,
// plus a one-hot to index helper that the arbiter can reuse.
package bus_controller_pkg;

  localparam int NUM_CPUS  = 4;
  localparam int CPU_IDX_W = $clog2(NUM_CPUS);

  typedef enum logic [1:0] {
    BusRd   = 2'd0,
    BusRdX  = 2'd1,
    BusUpgr = 2'd2,
    WB      = 2'd3
  } bus_cmd_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SNOOP   = 3'd1,
    COLLECT = 3'd2,
    MEM_WR  = 3'd3,
    MEM_RD  = 3'd4,
    RESP    = 3'd5
  } state_t;

  // Multi-hot inputs resolve to the lowest set bit.
  function automatic logic [CPU_IDX_W-1:0] onehot_to_idx(input logic [NUM_CPUS-1:0] oh);
    logic [CPU_IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CPUS - 1; i >= 0; i--) begin
      if (oh[i]) idx = CPU_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_controller_if.sv
// Bus-side bundle of bus_controller: arbiter grant/busy, per-CPU requests,
// snoop broadcast and responses, memory port and requester response.
interface bus_controller_if
  import bus_controller_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) ();

  logic [NUM_CPUS-1:0] gnt;
  logic [NUM_CPUS-1:0] busy;
  bus_cmd_t            cpu_cmd   [NUM_CPUS];
  logic [ADDR_W-1:0]   cpu_addr  [NUM_CPUS];
  logic [LINE_W-1:0]   cpu_wdata [NUM_CPUS];

  logic [NUM_CPUS-1:0] snp_valid;
  bus_cmd_t            snp_cmd;
  logic [ADDR_W-1:0]   snp_addr;
  logic [NUM_CPUS-1:0] snp_ack;
  logic [NUM_CPUS-1:0] snp_shared;
  logic [NUM_CPUS-1:0] snp_dirty;
  logic [LINE_W-1:0]   snp_data  [NUM_CPUS];

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [LINE_W-1:0]   mem_wdata;
  logic                mem_ready;
  logic                mem_rvalid;
  logic [LINE_W-1:0]   mem_rdata;

  logic [NUM_CPUS-1:0] resp_valid;
  logic [LINE_W-1:0]   resp_data;
  logic                resp_shared;

  modport master (
    input  gnt, cpu_cmd, cpu_addr, cpu_wdata,
    input  snp_ack, snp_shared, snp_dirty, snp_data,
    input  mem_ready, mem_rvalid, mem_rdata,
    output busy, snp_valid, snp_cmd, snp_addr,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output resp_valid, resp_data, resp_shared
  );

  modport slave (
    output gnt, cpu_cmd, cpu_addr, cpu_wdata,
    output snp_ack, snp_shared, snp_dirty, snp_data,
    output mem_ready, mem_rvalid, mem_rdata,
    input  busy, snp_valid, snp_cmd, snp_addr,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  resp_valid, resp_data, resp_shared
  );

endinterface

// File: rtl/bus_controller.sv
// Snoop-bus transaction controller: latches the granted request, snoops the peers,
// sources the line from a dirty peer (with writeback) or memory, and responds.
module bus_controller
  import bus_controller_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input logic              clk,
  input logic              rst,
  bus_controller_if.master bus
);

  state_t               state_q, state_d;
  logic [CPU_IDX_W-1:0] owner_q, owner_d;
  bus_cmd_t             cmd_q, cmd_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LINE_W-1:0]    line_q, line_d;
  logic [NUM_CPUS-1:0]  ack_q, ack_d;
  logic [NUM_CPUS-1:0]  shr_q, shr_d;
  logic [NUM_CPUS-1:0]  dty_q, dty_d;
  logic                 acc_q, acc_d;

  logic [CPU_IDX_W-1:0] gnt_idx;
  logic [CPU_IDX_W-1:0] cap_idx;
  logic [NUM_CPUS-1:0]  own_oh;
  logic [NUM_CPUS-1:0]  peers;
  logic [NUM_CPUS-1:0]  new_ack;
  logic [NUM_CPUS-1:0]  new_dty;
  logic                 cap_vld;

  assign gnt_idx = onehot_to_idx(bus.gnt);
  assign own_oh  = NUM_CPUS'(1) << owner_q;
  assign peers   = ~own_oh;
  assign new_ack = bus.snp_ack & peers & ~ack_q;
  assign new_dty = new_ack & bus.snp_dirty;

  // The lowest dirty index wins even if a higher one already supplied data.
  always_comb begin
    cap_idx = onehot_to_idx(new_dty);
    cap_vld = (new_dty != '0) &&
              ((dty_q & ((NUM_CPUS'(1) << cap_idx) - NUM_CPUS'(1))) == '0);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    line_d  = line_q;
    ack_d   = ack_q;
    shr_d   = shr_q;
    dty_d   = dty_q;
    acc_d   = acc_q;

    case (state_q)
      IDLE: begin
        if (bus.gnt != '0) begin
          owner_d = gnt_idx;
          cmd_d   = bus.cpu_cmd[gnt_idx];
          addr_d  = bus.cpu_addr[gnt_idx];
          line_d  = (bus.cpu_cmd[gnt_idx] == WB) ? bus.cpu_wdata[gnt_idx] : '0;
          ack_d   = '0;
          shr_d   = '0;
          dty_d   = '0;
          acc_d   = 1'b0;
          state_d = (bus.cpu_cmd[gnt_idx] == WB) ? MEM_WR : SNOOP;
        end
      end

      SNOOP, COLLECT: begin
        ack_d = ack_q | new_ack;
        shr_d = shr_q | (new_ack & bus.snp_shared);
        dty_d = dty_q | new_dty;
        if (cap_vld && (cmd_q != BusUpgr)) line_d = bus.snp_data[cap_idx];
        if (state_q == SNOOP) begin
          state_d = COLLECT;
        end else if (ack_d == peers) begin
          if (cmd_q == BusUpgr)  state_d = RESP;
          else if (dty_d != '0)  state_d = MEM_WR;
          else                   state_d = MEM_RD;
        end
      end

      MEM_WR: begin
        if (bus.mem_ready) state_d = RESP;
      end

      MEM_RD: begin
        if (!acc_q) begin
          if (bus.mem_ready) acc_d = 1'b1;
        end else if (bus.mem_rvalid) begin
          line_d  = bus.mem_rdata;
          state_d = RESP;
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      cmd_q   <= BusRd;
      addr_q  <= '0;
      line_q  <= '0;
      ack_q   <= '0;
      shr_q   <= '0;
      dty_q   <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      ack_q   <= ack_d;
      shr_q   <= shr_d;
      dty_q   <= dty_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.busy        = {NUM_CPUS{state_q != IDLE}};
  assign bus.snp_valid   = (state_q == SNOOP) ? peers : '0;
  assign bus.snp_cmd     = cmd_q;
  assign bus.snp_addr    = addr_q;
  assign bus.mem_req     = (state_q == MEM_WR) || ((state_q == MEM_RD) && !acc_q);
  assign bus.mem_we      = (state_q == MEM_WR);
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = line_q;
  // WB owners get an empty completion; BusRdX/BusUpgr always install exclusive.
  assign bus.resp_valid  = (state_q == RESP) ? own_oh : '0;
  assign bus.resp_data   = ((state_q == RESP) && (cmd_q != WB)) ? line_q : '0;
  assign bus.resp_shared = (state_q == RESP) && (cmd_q == BusRd) && (shr_q != '0);

endmodule

// File: tb/tb_bus_controller.sv
// Randomized bench for bus_controller: a per-transaction reference computes expected
// timing and data from the protocol rules; the bench plays the peer caches and memory.
module tb_bus_controller;
  import bus_controller_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int MAX_CYC = 60;

  logic clk = 1'b0;
  logic rst;

  bus_controller_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();
  bus_controller #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic check_val(input string tag, input logic [LINE_W-1:0] obs,
                           input logic [LINE_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Current transaction description
  int                  t_owner;
  bus_cmd_t            t_cmd;
  logic [ADDR_W-1:0]   t_addr;
  logic [LINE_W-1:0]   t_wdata;
  logic [LINE_W-1:0]   t_mem_line;
  logic [LINE_W-1:0]   t_snp_line [NUM_CPUS];
  int                  t_ack_dly  [NUM_CPUS];
  logic [NUM_CPUS-1:0] t_shr, t_dty, t_gnt_extra;
  int                  t_rdy_dly, t_rv_dly;

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.gnt        = '0;
    bus.snp_ack    = '0;
    bus.snp_shared = '0;
    bus.snp_dirty  = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      bus.cpu_cmd[i]   = BusRd;
      bus.cpu_addr[i]  = '0;
      bus.cpu_wdata[i] = '0;
      bus.snp_data[i]  = '0;
    end
  endtask

  task automatic rand_txn();
    t_owner    = $urandom_range(0, NUM_CPUS - 1);
    t_cmd      = bus_cmd_t'($urandom_range(0, 3));
    t_addr     = $urandom;
    t_wdata    = rand_line();
    t_mem_line = rand_line();
    for (int i = 0; i < NUM_CPUS; i++) begin
      t_ack_dly[i]  = $urandom_range(0, 4);
      t_snp_line[i] = rand_line();
    end
    t_dty       = ($urandom_range(0, 2) == 0) ? NUM_CPUS'($urandom) : '0;
    t_shr       = NUM_CPUS'($urandom) | t_dty;
    t_gnt_extra = ($urandom_range(0, 3) == 0) ? NUM_CPUS'($urandom) : '0;
    t_rdy_dly   = $urandom_range(0, 3);
    t_rv_dly    = $urandom_range(0, 3);
  endtask

  task automatic run_txn(input string name);
    logic [NUM_CPUS-1:0] own_oh, peers, gx, obs_snp, obs_rv;
    int                  last_ack, exit_c, dirty_idx, exp_resp, exp_nreq;
    logic [LINE_W-1:0]   exp_data, exp_wdata, obs_data, obs_wdata;
    logic                exp_shared, exp_we, obs_shared, obs_we;
    logic [ADDR_W-1:0]   obs_maddr, obs_saddr;
    bus_cmd_t            obs_scmd;
    int                  obs_resp_c, req_cnt, rv_c, busy_bad, extra_resp;

    own_oh = NUM_CPUS'(1) << t_owner;
    peers  = ~own_oh;
    gx     = t_gnt_extra & ~((own_oh << 1) - NUM_CPUS'(1));

    // Reference: snoop in cycle 1, collect from cycle 2 until the last peer ack.
    last_ack = 0;
    for (int i = 0; i < NUM_CPUS; i++)
      if (i != t_owner && 1 + t_ack_dly[i] > last_ack) last_ack = 1 + t_ack_dly[i];
    exit_c    = (last_ack > 2) ? last_ack : 2;
    dirty_idx = -1;
    for (int i = NUM_CPUS - 1; i >= 0; i--)
      if (i != t_owner && t_dty[i]) dirty_idx = i;
    exp_shared = (t_cmd == BusRd) && ((t_shr & peers) != '0);
    exp_data   = '0;
    exp_wdata  = '0;
    exp_we     = 1'b0;
    if (t_cmd == WB) begin
      exp_nreq = t_rdy_dly + 1;  exp_resp = 2 + t_rdy_dly;
      exp_we   = 1'b1;           exp_wdata = t_wdata;
    end else if (t_cmd == BusUpgr) begin
      exp_nreq = 0;              exp_resp = exit_c + 1;
    end else if (dirty_idx >= 0) begin
      exp_nreq = t_rdy_dly + 1;  exp_resp = exit_c + 2 + t_rdy_dly;
      exp_we   = 1'b1;           exp_wdata = t_snp_line[dirty_idx];
      exp_data = exp_wdata;
    end else begin
      exp_nreq = t_rdy_dly + 1;  exp_resp = exit_c + 3 + t_rdy_dly + t_rv_dly;
      exp_data = t_mem_line;
    end

    obs_resp_c = -1; req_cnt = 0; rv_c = -1; busy_bad = 0; extra_resp = 0;
    obs_snp = '0; obs_rv = '0; obs_data = '0; obs_wdata = '0; obs_shared = 1'b0;
    obs_we = 1'b0; obs_maddr = '0; obs_saddr = '0; obs_scmd = BusRd;

    for (int c = 0; c <= exp_resp + 2 && c < MAX_CYC; c++) begin
      @(posedge clk); #1;
      bus.gnt = (c == 0) ? (own_oh | gx) : '0;
      for (int i = 0; i < NUM_CPUS; i++) begin
        if (c == 0 && i == t_owner) begin
          bus.cpu_cmd[i]   = t_cmd;
          bus.cpu_addr[i]  = t_addr;
          bus.cpu_wdata[i] = t_wdata;
        end else begin
          bus.cpu_cmd[i]   = bus_cmd_t'($urandom_range(0, 3));
          bus.cpu_addr[i]  = $urandom;
          bus.cpu_wdata[i] = rand_line();
        end
        if (i == t_owner) begin
          bus.snp_ack[i]    = 1'($urandom_range(0, 1));
          bus.snp_shared[i] = 1'($urandom_range(0, 1));
          bus.snp_dirty[i]  = 1'($urandom_range(0, 1));
          bus.snp_data[i]   = rand_line();
        end else if (t_cmd != WB && c == 1 + t_ack_dly[i]) begin
          bus.snp_ack[i]    = 1'b1;
          bus.snp_shared[i] = t_shr[i];
          bus.snp_dirty[i]  = t_dty[i];
          bus.snp_data[i]   = t_dty[i] ? t_snp_line[i] : rand_line();
        end else begin
          bus.snp_ack[i]    = 1'b0;
          bus.snp_shared[i] = 1'($urandom_range(0, 1));
          bus.snp_dirty[i]  = 1'($urandom_range(0, 1));
          bus.snp_data[i]   = rand_line();
        end
      end
      if (bus.mem_req) req_cnt++;
      bus.mem_ready = bus.mem_req && (req_cnt > t_rdy_dly);
      if (bus.mem_ready && !bus.mem_we) rv_c = c + 1 + t_rv_dly;
      bus.mem_rvalid = (c == rv_c);
      bus.mem_rdata  = (c == rv_c) ? t_mem_line : rand_line();

      @(negedge clk);
      if (c == 1) begin
        obs_snp   = bus.snp_valid;
        obs_saddr = bus.snp_addr;
        obs_scmd  = bus.snp_cmd;
      end
      if (c >= 1 && c <= exp_resp) begin
        if (bus.busy !== {NUM_CPUS{1'b1}}) busy_bad++;
      end else if (bus.busy !== '0) busy_bad++;
      if (bus.mem_req && req_cnt == 1) begin
        obs_we    = bus.mem_we;
        obs_wdata = bus.mem_wdata;
        obs_maddr = bus.mem_addr;
      end
      if (bus.resp_valid != '0) begin
        if (obs_resp_c < 0) begin
          obs_resp_c = c;
          obs_rv     = bus.resp_valid;
          obs_data   = bus.resp_data;
          obs_shared = bus.resp_shared;
        end else extra_resp++;
      end
    end
    idle_inputs();

    check_val({name, ".resp_cycle"}, obs_resp_c, exp_resp);
    check_val({name, ".resp_valid"}, obs_rv, own_oh);
    check_val({name, ".resp_data"}, obs_data, exp_data);
    check_val({name, ".resp_shared"}, obs_shared, exp_shared);
    check_val({name, ".extra_resp"}, extra_resp, 0);
    check_val({name, ".busy_bad_cycles"}, busy_bad, 0);
    check_val({name, ".mem_req_cycles"}, req_cnt, exp_nreq);
    if (exp_nreq > 0) begin
      check_val({name, ".mem_we"}, obs_we, exp_we);
      check_val({name, ".mem_addr"}, obs_maddr, t_addr);
    end
    if (exp_we) check_val({name, ".mem_wdata"}, obs_wdata, exp_wdata);
    if (t_cmd != WB) begin
      check_val({name, ".snp_valid"}, obs_snp, peers);
      check_val({name, ".snp_addr"}, obs_saddr, t_addr);
      check_val({name, ".snp_cmd"}, obs_scmd, t_cmd);
    end
  endtask

  task automatic reset_mid_txn();
    int bad;
    @(posedge clk); #1;
    bus.gnt         = NUM_CPUS'(1);
    bus.cpu_cmd[0]  = BusRd;
    bus.cpu_addr[0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.gnt        = '0;
    bus.snp_ack    = 4'b0010;
    bus.snp_shared = 4'b0010;
    @(posedge clk); #1;
    bus.snp_ack    = '0;
    bus.snp_shared = '0;
    @(posedge clk); #3;
    check_val("rst_mid.busy_before", bus.busy, {NUM_CPUS{1'b1}});
    rst = 1'b0;
    #1;
    check_val("rst_mid.busy", bus.busy, '0);
    check_val("rst_mid.snp_valid", bus.snp_valid, '0);
    check_val("rst_mid.mem_req", bus.mem_req, '0);
    check_val("rst_mid.mem_we", bus.mem_we, '0);
    check_val("rst_mid.snp_addr", bus.snp_addr, '0);
    check_val("rst_mid.mem_addr", bus.mem_addr, '0);
    bad = 0;
    repeat (3) @(negedge clk) if (bus.resp_valid != '0 || bus.busy != '0) bad++;
    rst = 1'b1;
    bus.snp_ack    = 4'b1100;
    bus.snp_shared = 4'b1100;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid != '0 || bus.busy != '0) bad++;
      bus.snp_ack    = '0;
      bus.snp_shared = '0;
    end
    check_val("rst_mid.no_resp", bad, 0);
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_val("reset.busy", bus.busy, '0);
    check_val("reset.snp_valid", bus.snp_valid, '0);
    check_val("reset.mem_req", bus.mem_req, '0);
    check_val("reset.resp_valid", bus.resp_valid, '0);
    check_val("reset.mem_addr", bus.mem_addr, '0);
    check_val("reset.resp_data", bus.resp_data, '0);
    rst = 1'b1;

    // BusRd miss from CPU0, peers ack at T+2, memory returns A5 pattern
    rand_txn();
    t_owner = 0; t_cmd = BusRd; t_gnt_extra = '0; t_shr = '0; t_dty = '0;
    for (int i = 0; i < NUM_CPUS; i++) t_ack_dly[i] = 1;
    t_rdy_dly = 0; t_rv_dly = 0; t_mem_line = {(LINE_W / 8){8'hA5}};
    run_txn("rd_mem");

    // BusRd from CPU2, CPU1 dirty supplies 0x1234
    rand_txn();
    t_owner = 2; t_cmd = BusRd; t_gnt_extra = '0; t_shr = 4'b0010; t_dty = 4'b0010;
    for (int i = 0; i < NUM_CPUS; i++) t_ack_dly[i] = 0;
    t_rdy_dly = 0; t_snp_line[1] = LINE_W'(16'h1234);
    run_txn("rd_dirty");

    // BusUpgr from CPU3 with staggered acks
    rand_txn();
    t_owner = 3; t_cmd = BusUpgr; t_gnt_extra = '0;
    t_ack_dly[0] = 0; t_ack_dly[1] = 3; t_ack_dly[2] = 1;
    run_txn("upgr");

    // WB from CPU1 with mem_ready held off 3 cycles
    rand_txn();
    t_owner = 1; t_cmd = WB; t_gnt_extra = '0; t_rdy_dly = 3;
    run_txn("wb");

    reset_mid_txn();
    rand_txn();
    t_cmd = BusRd; t_gnt_extra = '0;
    run_txn("post_rst");

    for (int n = 0; n < 40; n++) begin
      rand_txn();
      run_txn($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
